// File: rtl/aes_192_sched_if.sv
// aes_192_sched_if: requester and response handshake bundle for aes_192_sched
interface aes_192_sched_if;
  logic         req0_valid;
  logic         req0_ready;
  logic [191:0] req0_key;
  logic [127:0] req0_state;
  logic         req1_valid;
  logic         req1_ready;
  logic [191:0] req1_key;
  logic [127:0] req1_state;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_id;
  modport slave (
    input  req0_valid, req0_key, req0_state, req1_valid, req1_key, req1_state, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
  );
  modport master (
    output req0_valid, req0_key, req0_state, req1_valid, req1_key, req1_state, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/aes_192_sched.sv
// aes_192_sched: two-port credit-checked request scheduler and result FIFO for aes_192; AES192_SCHED_RR_EN selects round-robin arbitration
module aes_192_sched #(
  parameter int LATENCY    = 13,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  aes_192_sched_if.slave      bus,
  output logic [191:0]        core_key,
  output logic [127:0]        core_state,
  input  logic [127:0]        core_out,
  output logic                busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(LATENCY + FIFO_DEPTH + 1);
  logic [OW-1:0]      r_infl, r_fcnt, w_occ;
  logic [LATENCY-1:0] r_tv, r_tid;
  logic [AW-1:0]      r_rd, r_wr;
  logic [127:0]       r_data [FIFO_DEPTH];
  logic               r_idm  [FIFO_DEPTH];
  logic               w_gnt, w_credit, w_acc, w_push, w_pop, w_ne;
  assign w_occ    = r_infl + r_fcnt;
  assign w_credit = w_occ < OW'(FIFO_DEPTH);
`ifdef AES192_SCHED_RR_EN
  logic r_ptr;
  assign w_gnt = (bus.req0_valid & bus.req1_valid) ? r_ptr : bus.req1_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= 1'b0;
    else if (w_acc) r_ptr <= ~w_gnt;
`else
  assign w_gnt = ~bus.req0_valid & bus.req1_valid;
`endif
  assign bus.req0_ready = w_credit & bus.req0_valid & ~w_gnt;
  assign bus.req1_ready = w_credit & bus.req1_valid & w_gnt;
  assign w_acc          = bus.req0_ready | bus.req1_ready;
  assign w_push         = r_tv[LATENCY-1];
  assign w_ne           = r_fcnt != '0;
  assign w_pop          = w_ne & bus.rsp_ready;
  assign bus.rsp_valid  = w_ne;
  assign bus.rsp_data   = w_ne ? r_data[r_rd] : '0;
  assign bus.rsp_id     = w_ne & r_idm[r_rd];
  assign busy           = w_occ != '0;
  // the tag pipe mirrors the core so each result is captured with its requester id
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_infl     <= '0;
      r_fcnt     <= '0;
      r_tv       <= '0;
      r_tid      <= '0;
      r_rd       <= '0;
      r_wr       <= '0;
      core_key   <= '0;
      core_state <= '0;
    end else begin
      r_tv   <= LATENCY'({r_tv, w_acc});
      r_tid  <= LATENCY'({r_tid, w_gnt});
      r_infl <= r_infl + OW'(w_acc) - OW'(w_push);
      r_fcnt <= r_fcnt + OW'(w_push) - OW'(w_pop);
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      if (w_acc) begin
        core_key   <= w_gnt ? bus.req1_key : bus.req0_key;
        core_state <= w_gnt ? bus.req1_state : bus.req0_state;
      end
    end
  always_ff @(posedge clk)
    if (w_push) begin
      r_data[r_wr] <= core_out;
      r_idm[r_wr]  <= r_tid[LATENCY-1];
    end
endmodule
